// File: rtl/exec_unit_pipe.sv
// Integer execute unit: single-cycle ALU, fixed-latency multiplier and an
// iterative restoring divider behind a valid/ready handshake with a tag.
module exec_unit_pipe #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int CNT_W    = 7;
  localparam int MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   result_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [XLEN-1:0]   a_reg, b_reg, rem_reg;
  logic [1:0]        mop_reg;
  logic              word_reg, neg_q_reg, neg_r_reg, rem_sel_reg;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  // Operand signedness per sel: 00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u).
  function automatic logic [XLEN-1:0] mul_calc(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [1:0]      sel,
                                               input logic            w);
    logic [2*XLEN-1:0] ax, bx, p;
    logic a_sgn, b_sgn;
    a_sgn = (sel == 2'b01) || (sel == 2'b10);
    b_sgn = (sel == 2'b01);
    ax    = {{XLEN{a_sgn & a[XLEN-1]}}, a};
    bx    = {{XLEN{b_sgn & b[XLEN-1]}}, b};
    p     = ax * bx;
    if (sel == 2'b00) return w ? sext32(p[31:0]) : p[XLEN-1:0];
    return p[2*XLEN-1:XLEN];
  endfunction

  // Decode and operand shaping
  logic            wd, w32, is_mul, is_div, accept;
  logic [5:0]      shamt;
  logic [31:0]     sra_w;
  logic [XLEN-1:0] sra_d, alu_res;

  assign wd     = (XLEN == 64) ? word_i : 1'b0;
  assign w32    = (XLEN == 32) ? 1'b1 : word_i;
  assign is_mul = (op_i[4:2] == 3'b100);
  assign is_div = (op_i[4:2] == 3'b101);
  assign shamt  = (XLEN == 64 && !wd) ? op2_i[5:0] : {1'b0, op2_i[4:0]};
  assign sra_w  = $signed(op1_i[31:0]) >>> shamt[4:0];
  assign sra_d  = $signed(op1_i) >>> shamt;
  assign accept = in_valid_i & in_ready_o;

  always_comb begin
    alu_res = '0;
    case (op_i)
      OP_ADD:  alu_res = wd ? sext32(op1_i[31:0] + op2_i[31:0]) : op1_i + op2_i;
      OP_SUB:  alu_res = wd ? sext32(op1_i[31:0] - op2_i[31:0]) : op1_i - op2_i;
      OP_SLL:  alu_res = wd ? sext32(op1_i[31:0] << shamt[4:0]) : op1_i << shamt;
      OP_SLT:  alu_res[0] = $signed(op1_i) < $signed(op2_i);
      OP_SLTU: alu_res[0] = op1_i < op2_i;
      OP_XOR:  alu_res = op1_i ^ op2_i;
      OP_SRL:  alu_res = wd ? sext32(op1_i[31:0] >> shamt[4:0]) : op1_i >> shamt;
      OP_SRA:  alu_res = wd ? sext32(sra_w) : sra_d;
      OP_OR:   alu_res = op1_i | op2_i;
      OP_AND:  alu_res = op1_i & op2_i;
      default: alu_res = '0;
    endcase
  end

  // Divider setup: W-variant operands are widened first so sign tests use the top bit.
  logic            div_sgn, dvd_neg, dvs_neg, dvs_zero, div_ovf, div_special;
  logic [XLEN-1:0] dvd_val, dvs_val, dvd_mag, dvs_mag, min_val, spec_raw, spec_res;

  always_comb begin
    div_sgn     = ~op_i[0];
    dvd_val     = w32 ? (div_sgn ? sext32(op1_i[31:0]) : zext32(op1_i[31:0])) : op1_i;
    dvs_val     = w32 ? (div_sgn ? sext32(op2_i[31:0]) : zext32(op2_i[31:0])) : op2_i;
    dvd_neg     = div_sgn & dvd_val[XLEN-1];
    dvs_neg     = div_sgn & dvs_val[XLEN-1];
    dvd_mag     = dvd_neg ? -dvd_val : dvd_val;
    dvs_mag     = dvs_neg ? -dvs_val : dvs_val;
    min_val     = w32 ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    dvs_zero    = (dvs_val == '0);
    div_ovf     = div_sgn & (dvd_val == min_val) & (&dvs_val);
    div_special = dvs_zero | div_ovf;
    if (op_i[1]) spec_raw = dvs_zero ? dvd_val : '0;
    else         spec_raw = dvs_zero ? '1 : dvd_val;
    spec_res    = w32 ? sext32(spec_raw[31:0]) : spec_raw;
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_sub, rem_new, q_new, q_fin, r_fin, div_raw, div_res;
  logic            ge;

  always_comb begin
    rem_shift = {rem_reg, a_reg[XLEN-1]};
    ge        = (rem_shift >= {1'b0, b_reg});
    rem_sub   = rem_shift[XLEN-1:0] - b_reg;
    rem_new   = ge ? rem_sub : rem_shift[XLEN-1:0];
    q_new     = {a_reg[XLEN-2:0], ge};
    q_fin     = neg_q_reg ? -q_new : q_new;
    r_fin     = neg_r_reg ? -rem_new : rem_new;
    div_raw   = rem_sel_reg ? r_fin : q_fin;
    div_res   = word_reg ? sext32(div_raw[31:0]) : div_raw;
  end

  logic   mul_last, div_last;
  state_t accept_state;

  assign mul_last = (cnt_reg == CNT_W'(MUL_LAST));
  assign div_last = (cnt_reg == (word_reg ? CNT_W'(31) : CNT_W'(XLEN - 1)));

  always_comb begin
    accept_state = DONE;
    if (is_mul && MUL_LAT > 1)       accept_state = MUL;
    else if (is_div && !div_special) accept_state = DIV;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = accept_state;
        MUL:  if (mul_last) state_next = DONE;
        DIV:  if (div_last) state_next = DONE;
        DONE: if (out_ready_i) state_next = accept ? accept_state : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = ~flush_i & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready_i));
    out_valid_o = (state_reg == DONE);
    busy_o      = (state_reg == MUL) | (state_reg == DIV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      result_reg  <= '0;
      tag_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      rem_reg     <= '0;
      mop_reg     <= '0;
      word_reg    <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
    end else if (flush_i) begin
      cnt_reg <= '0;
    end else if (accept) begin
      tag_reg <= tag_i;
      cnt_reg <= '0;
      if (is_mul) begin
        a_reg    <= op1_i;
        b_reg    <= op2_i;
        mop_reg  <= op_i[1:0];
        word_reg <= wd;
        if (MUL_LAT == 1) result_reg <= mul_calc(op1_i, op2_i, op_i[1:0], wd);
      end else if (is_div) begin
        a_reg       <= w32 ? (dvd_mag << (XLEN - 32)) : dvd_mag;
        b_reg       <= dvs_mag;
        rem_reg     <= '0;
        word_reg    <= w32;
        neg_q_reg   <= dvd_neg ^ dvs_neg;
        neg_r_reg   <= dvd_neg;
        rem_sel_reg <= op_i[1];
        if (div_special) result_reg <= spec_res;
      end else begin
        result_reg <= alu_res;
      end
    end else if (state_reg == MUL) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (mul_last) result_reg <= mul_calc(a_reg, b_reg, mop_reg, word_reg);
    end else if (state_reg == DIV) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      a_reg   <= q_new;
      rem_reg <= rem_new;
      if (div_last) result_reg <= div_res;
    end
  end

  assign result_o = result_reg;
  assign tag_o    = tag_reg;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed bench for exec_unit_pipe (XLEN=64, MUL_LAT=3): ALU, mul, div,
// special divides, flush, reset abort, back-pressure and back-to-back flow.
module tb_exec_unit_pipe;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3;
  localparam logic [4:0] SLTU = 5'd4, XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7;
  localparam logic [4:0] OR = 5'd8,   AND = 5'd9,  BAD = 5'd12;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22,  REMU = 5'd23;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid_i, in_ready_o, word_i;
  logic        out_valid_o, out_ready_i, busy_o;
  logic [4:0]  op_i, tag_i, tag_o;
  logic [63:0] op1_i, op2_i, result_o;
  int          vectors = 0;
  int          fails = 0;
  logic        seen;

  always #5 clk = ~clk;

  exec_unit_pipe #(.XLEN(64), .TAG_W(5), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .word_i(word_i), .op1_i(op1_i), .op2_i(op2_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  task automatic chk_bit(input string name, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_int(input string name, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tg);
    op_i = op; word_i = w; op1_i = a; op2_i = b; tag_i = tg; in_valid_i = 1'b1;
    #1;
    chk_bit("accept_ready", in_ready_o, 1'b1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  // Cycle 1 is the cycle right after acceptance; multi-cycle ops must show busy while waiting.
  task automatic expect_result(input string name, input int lat_exp, input logic [63:0] res,
                               input logic [4:0] tg, input logic multi);
    int lat = 1;
    while (out_valid_o !== 1'b1 && lat < 200) begin
      if (multi) chk_bit({name, "_busy"}, busy_o, 1'b1);
      step();
      lat++;
    end
    chk_int({name, "_lat"}, lat, lat_exp);
    chk_word(name, result_o, res);
    chk_int({name, "_tag"}, int'(tag_o), int'(tg));
    chk_bit({name, "_busy_done"}, busy_o, 1'b0);
    $display("vector %-10s result=%h tag=%0d latency=%0d", name, result_o, tag_o, lat);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    op_i = '0; word_i = 1'b0; op1_i = '0; op2_i = '0; tag_i = '0;
    repeat (3) step();
    chk_bit("rst_out_valid", out_valid_o, 1'b0);
    chk_bit("rst_busy", busy_o, 1'b0);
    chk_word("rst_result", result_o, 64'd0);
    chk_int("rst_tag", int'(tag_o), 0);
    rst = 1'b0;
    step();
    chk_bit("rst_in_ready", in_ready_o, 1'b1);

    // ALU
    issue(ADD, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3);
    expect_result("add", 1, 64'd2, 5'd3, 1'b0);
    issue(ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 5'd4);
    expect_result("addw", 1, 64'hFFFF_FFFF_8000_0000, 5'd4, 1'b0);
    issue(SUB, 1'b0, 64'd3, 64'd5, 5'd5);
    expect_result("sub", 1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd5, 1'b0);
    issue(SLL, 1'b0, 64'd1, 64'h68, 5'd6);
    expect_result("sll", 1, 64'h0000_0100_0000_0000, 5'd6, 1'b0);
    issue(SLL, 1'b1, 64'd1, 64'h3F, 5'd7);
    expect_result("sllw", 1, 64'hFFFF_FFFF_8000_0000, 5'd7, 1'b0);
    issue(SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd8);
    expect_result("sra", 1, 64'hF800_0000_0000_0000, 5'd8, 1'b0);
    issue(SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 5'd9);
    expect_result("sraw", 1, 64'hFFFF_FFFF_F800_0000, 5'd9, 1'b0);
    issue(SRL, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 5'd10);
    expect_result("srl", 1, 64'd1, 5'd10, 1'b0);
    issue(SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd11);
    expect_result("slt", 1, 64'd1, 5'd11, 1'b0);
    issue(SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd12);
    expect_result("sltu", 1, 64'd0, 5'd12, 1'b0);
    issue(XOR, 1'b0, 64'hFF00, 64'h0FF0, 5'd13);
    expect_result("xor", 1, 64'hF0F0, 5'd13, 1'b0);
    issue(OR, 1'b0, 64'hF000, 64'h000F, 5'd14);
    expect_result("or", 1, 64'hF00F, 5'd14, 1'b0);
    issue(AND, 1'b0, 64'hF0F0, 64'hFF00, 5'd15);
    expect_result("and", 1, 64'hF000, 5'd15, 1'b0);
    issue(BAD, 1'b0, 64'd5, 64'd6, 5'd16);
    expect_result("badop", 1, 64'd0, 5'd16, 1'b0);

    // Multiply family
    issue(MUL, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd17);
    expect_result("mul", 3, 64'd0, 5'd17, 1'b1);
    issue(MULHU, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd18);
    expect_result("mulhu", 3, 64'd1, 5'd18, 1'b1);
    issue(MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd19);
    expect_result("mulh", 3, 64'd0, 5'd19, 1'b1);
    issue(MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd20);
    expect_result("mulhsu", 3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd20, 1'b1);
    issue(MUL, 1'b0, 64'd7, 64'd6, 5'd21);
    expect_result("mul7x6", 3, 64'd42, 5'd21, 1'b1);
    issue(MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd22);
    expect_result("mulw", 3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd22, 1'b1);

    // Divide family
    issue(DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd23);
    expect_result("div", 65, 64'hFFFF_FFFF_FFFF_FFF2, 5'd23, 1'b1);
    issue(REM, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd24);
    expect_result("rem", 65, 64'd2, 5'd24, 1'b1);
    issue(DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd25);
    expect_result("divuw", 33, 64'h0000_0000_7FFF_FFFF, 5'd25, 1'b1);
    issue(REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd26);
    expect_result("remw", 33, 64'hFFFF_FFFF_FFFF_FFFF, 5'd26, 1'b1);
    issue(DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd27);
    expect_result("divu", 65, 64'h5555_5555_5555_5555, 5'd27, 1'b1);
    issue(DIVU, 1'b0, 64'd5, 64'd0, 5'd28);
    expect_result("divu_by0", 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd28, 1'b0);
    issue(REM, 1'b0, 64'd5, 64'd0, 5'd29);
    expect_result("rem_by0", 1, 64'd5, 5'd29, 1'b0);
    issue(REMU, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 5'd30);
    expect_result("remuw_by0", 1, 64'hFFFF_FFFF_8000_0001, 5'd30, 1'b0);
    issue(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
    expect_result("div_ovf", 1, 64'h8000_0000_0000_0000, 5'd31, 1'b0);
    issue(REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    expect_result("rem_ovf", 1, 64'd0, 5'd1, 1'b0);
    step();

    // Flush mid-divide: offered op in the flush cycle must be refused
    issue(DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd2);
    repeat (9) step();
    flush_i = 1'b1; in_valid_i = 1'b1; op_i = ADD; word_i = 1'b0;
    op1_i = 64'd1; op2_i = 64'd1; tag_i = 5'd3;
    #1;
    chk_bit("flush_in_ready", in_ready_o, 1'b0);
    chk_bit("flush_busy_before", busy_o, 1'b1);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    #1;
    chk_bit("flush_busy_after", busy_o, 1'b0);
    chk_bit("flush_in_ready_after", in_ready_o, 1'b1);
    chk_bit("flush_out_valid", out_valid_o, 1'b0);
    seen = 1'b0;
    repeat (70) begin
      step();
      if (out_valid_o === 1'b1) seen = 1'b1;
    end
    chk_bit("flush_no_result", seen, 1'b0);
    $display("vector flush      stray_result=%b", seen);

    // Back-pressure: result held, nothing accepted
    out_ready_i = 1'b0;
    issue(ADD, 1'b0, 64'd10, 64'd20, 5'd9);
    in_valid_i = 1'b1; op_i = ADD; op1_i = 64'd1; op2_i = 64'd2; tag_i = 5'd4;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_bit("stall_valid", out_valid_o, 1'b1);
      chk_word("stall_result", result_o, 64'd30);
      chk_int("stall_tag", int'(tag_o), 9);
      chk_bit("stall_in_ready", in_ready_o, 1'b0);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    chk_bit("release_in_ready", in_ready_o, 1'b1);
    step();
    chk_bit("swap_valid", out_valid_o, 1'b1);
    chk_word("swap_result", result_o, 64'd3);
    chk_int("swap_tag", int'(tag_o), 4);
    $display("vector stall      result=%h tag=%0d", result_o, tag_o);

    // Back-to-back ALU ops, one result per cycle
    for (int k = 1; k <= 4; k++) begin
      op1_i = 64'(k * 100); op2_i = 64'(k); tag_i = 5'(k + 10);
      step();
      chk_bit("b2b_valid", out_valid_o, 1'b1);
      chk_word("b2b_result", result_o, 64'(k * 101));
      chk_int("b2b_tag", int'(tag_o), k + 10);
      $display("vector b2b%0d      result=%h tag=%0d", k, result_o, tag_o);
    end
    in_valid_i = 1'b0;
    step();
    chk_bit("drain_valid", out_valid_o, 1'b0);

    // Reset in the middle of a divide aborts it
    issue(DIV, 1'b0, 64'd100, 64'd7, 5'd23);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk_bit("midrst_busy", busy_o, 1'b0);
    chk_bit("midrst_valid", out_valid_o, 1'b0);
    chk_word("midrst_result", result_o, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      step();
      if (out_valid_o === 1'b1) seen = 1'b1;
    end
    chk_bit("midrst_no_result", seen, 1'b0);
    issue(DIV, 1'b0, 64'd100, 64'd7, 5'd6);
    expect_result("div_after", 65, 64'd14, 5'd6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
